// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, RX state type and sample vote helper
package uart_pkg;

  localparam int OVERSAMPLE_DEFAULT = 16;
  localparam int SAMPLE_LO          = 7;
  localparam int SAMPLE_MID         = 8;
  localparam int SAMPLE_HI          = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_rx_state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_bit_sampler.sv
// rtl/uart_rx_bit_sampler.sv - rx synchronizer, per-bit sample counter and 3-sample majority vote
module uart_rx_bit_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic uart_tick,
  input  logic rx,
  input  logic i_run,
  output logic o_rx_sync,
  output logic o_bit_val,
  output logic o_bit_strobe,
  output logic o_bit_end
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] LP_LO  = SW'(SAMPLE_LO);
  localparam logic [SW-1:0] LP_MID = SW'(SAMPLE_MID);
  localparam logic [SW-1:0] LP_HI  = SW'(SAMPLE_HI);
  localparam logic [SW-1:0] LP_END = SW'(OVERSAMPLE - 1);

  logic [1:0]    r_sync;
  logic [SW-1:0] r_scnt;
  logic          r_s_lo;
  logic          r_s_mid;
  logic          w_at_end;

  assign w_at_end = (r_scnt == LP_END);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], rx};
    end
  end

  // i_run reflects the FSM's next state, so the start tick lands on scnt=1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_scnt  <= '0;
      r_s_lo  <= 1'b1;
      r_s_mid <= 1'b1;
    end else if (uart_tick) begin
      if (!i_run || w_at_end) begin
        r_scnt <= '0;
      end else begin
        r_scnt <= r_scnt + 1'b1;
      end
      if (r_scnt == LP_LO) begin
        r_s_lo <= r_sync[1];
      end
      if (r_scnt == LP_MID) begin
        r_s_mid <= r_sync[1];
      end
    end
  end

  assign o_rx_sync    = r_sync[1];
  assign o_bit_val    = majority3(r_s_lo, r_s_mid, r_sync[1]);
  assign o_bit_strobe = uart_tick & (r_scnt == LP_HI);
  assign o_bit_end    = uart_tick & w_at_end;

endmodule

// File: rtl/uart_rx_oversampled.sv
// rtl/uart_rx_oversampled.sv - 16x oversampled UART receiver with one-entry valid/ack output
// Define UART_RX_PARITY_EN to add a parity bit, PARITY_ODD and the parity_err pulse.
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 uart_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 frame_err,
  output logic                 overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IW-1:0] LP_LAST = IW'(DATA_BITS - 1);

  uart_rx_state_t       r_state;
  uart_rx_state_t       w_next_state;
  logic [DATA_BITS-1:0] r_shreg;
  logic [DATA_BITS-1:0] r_data;
  logic [IW-1:0]        r_bit_idx;
  logic                 r_valid;
  logic                 r_overrun;
  logic                 r_frame_err;
  logic                 w_rx_sync;
  logic                 w_bit_val;
  logic                 w_bit_strobe;
  logic                 w_bit_end;
  logic                 w_shift;
  logic                 w_stop_decide;
  logic                 w_frame_bad;
  logic                 w_good;
  logic                 w_par_bad;

  uart_rx_bit_sampler #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_sampler (
    .clk         (clk),
    .reset       (reset),
    .uart_tick   (uart_tick),
    .rx          (rx),
    .i_run       (w_next_state != ST_IDLE),
    .o_rx_sync   (w_rx_sync),
    .o_bit_val   (w_bit_val),
    .o_bit_strobe(w_bit_strobe),
    .o_bit_end   (w_bit_end)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (uart_tick && !w_rx_sync) w_next_state = ST_START;
      end
      ST_START: begin
        if (w_bit_strobe && w_bit_val) w_next_state = ST_IDLE;
        else if (w_bit_end)            w_next_state = ST_DATA;
      end
      ST_DATA: begin
`ifdef UART_RX_PARITY_EN
        if (w_bit_end && r_bit_idx == LP_LAST) w_next_state = ST_PARITY;
`else
        if (w_bit_end && r_bit_idx == LP_LAST) w_next_state = ST_STOP;
`endif
      end
      ST_PARITY: begin
        if (w_bit_end) w_next_state = ST_STOP;
      end
      ST_STOP: begin
        // leave mid stop bit so the next start edge is never missed
        if (w_bit_strobe) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_shift       = 1'b0;
    w_stop_decide = 1'b0;
    w_frame_bad   = 1'b0;
    w_good        = 1'b0;
    w_shift       = (r_state == ST_DATA) && w_bit_strobe;
    w_stop_decide = (r_state == ST_STOP) && w_bit_strobe;
    w_frame_bad   = w_stop_decide && !w_bit_val;
    w_good        = w_stop_decide && w_bit_val && !w_par_bad;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shreg   <= '0;
      r_bit_idx <= '0;
    end else begin
      if (w_shift) begin
        r_shreg <= {w_bit_val, r_shreg[DATA_BITS-1:1]};
      end
      if (r_state == ST_START && w_bit_end) begin
        r_bit_idx <= '0;
      end else if (r_state == ST_DATA && w_bit_end && r_bit_idx != LP_LAST) begin
        r_bit_idx <= r_bit_idx + 1'b1;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_bit;
  logic r_parity_err;

  assign w_par_bad  = r_par_bit ^ (^r_shreg) ^ PARITY_ODD;
  assign parity_err = r_parity_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_par_bit    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if (r_state == ST_PARITY && w_bit_strobe) begin
        r_par_bit <= w_bit_val;
      end
      r_parity_err <= w_stop_decide && w_par_bad;
    end
  end
`else
  assign w_par_bad = 1'b0;
`endif

  // an ack in the same cycle frees the slot, so a held ack never overruns
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_frame_bad;
      if (rx_ack) begin
        r_overrun <= 1'b0;
      end
      if (w_good) begin
        if (!r_valid || rx_ack) begin
          r_data  <= r_shreg;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (rx_ack) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb/tb_uart_rx_oversampled.sv - directed scoreboard bench for uart_rx_oversampled (optional UART_RX_PARITY_EN)
module tb_uart_rx_oversampled;

  logic       clk    = 1'b0;
  logic       reset  = 1'b0;
  logic       rx     = 1'b1;
  logic       rx_ack = 1'b0;
  logic       uart_tick;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  logic       par_flip = 1'b0;
  int         pe_cnt   = 0;
  int         pe0;
`endif

  int         errors   = 0;
  int         checks   = 0;
  int         tick_div = 54;
  int         tick_cnt = 0;
  int         fe_cnt   = 0;
  int         fe0;
  logic [7:0] exp_q[$];
  logic [7:0] e_lr;

  always #5 clk = ~clk;

  always @(posedge clk) tick_cnt <= (tick_cnt >= tick_div - 1) ? 0 : tick_cnt + 1;
  assign uart_tick = (tick_cnt == tick_div - 1);

  always @(negedge clk) begin
    if (frame_err) fe_cnt <= fe_cnt + 1;
`ifdef UART_RX_PARITY_EN
    if (parity_err) pe_cnt <= pe_cnt + 1;
`endif
  end

  uart_rx_oversampled #(
    .DATA_BITS (8),
    .OVERSAMPLE(16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .uart_tick(uart_tick),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ack   (rx_ack),
    .frame_err(frame_err),
    .overrun  (overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tick();
    do @(negedge clk); while (!uart_tick);
  endtask

  // each tick-interval value is seen by the DUT one tick later, i.e. at scnt=k
  task automatic send_bit(input logic v, input int glitch_k);
    for (int k = 0; k < 16; k++) begin
      wait_tick();
      rx = (k == glitch_k) ? ~v : v;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input int glitch_bit);
    send_bit(1'b0, -1);
    for (int i = 0; i < 8; i++) send_bit(d[i], (i == glitch_bit) ? 8 : -1);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ par_flip, -1);
`endif
    send_bit(stop_v, -1);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) wait_tick();
  endtask

  task automatic expect_word(input string tag);
    int w;
    logic [7:0] e;
    w = 0;
    while (!rx_valid && w < 4000) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_valid"}, rx_valid, 1);
    e = 8'hxx;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    check({tag, "_data"}, rx_data, e);
  endtask

  task automatic ack_once();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_data", rx_data, 0);
    check("rst_valid", rx_valid, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
`ifdef UART_RX_PARITY_EN
    check("rst_perr", parity_err, 0);
`endif
    reset = 1'b1;
    idle(2);

    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, -1);
    expect_word("a5");
    repeat (5) @(negedge clk);
    check("a5_hold", rx_valid, 1);
    ack_once();
    check("a5_ack_clr", rx_valid, 0);

    // shorter tick period from here on keeps the run short
    tick_div = 6;
    idle(4);

    fe0 = fe_cnt;
    wait_tick();
    rx = 1'b0;
    repeat (5) wait_tick();
    idle(40);
    check("false_valid", rx_valid, 0);
    check("false_ferr", fe_cnt - fe0, 0);

    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, -1);
    idle(48);
    check("ferr_pulse", fe_cnt - fe0, 1);
    check("ferr_no_valid", rx_valid, 0);
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, -1);
    expect_word("after_ferr");
    ack_once();

    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1, -1);
    send_frame(8'h02, 1'b1, -1);
    expect_word("ovr_keep");
    check("ovr_set", overrun, 1);
    ack_once();
    check("ovr_ack_valid", rx_valid, 0);
    check("ovr_ack_clr", overrun, 0);

    exp_q.push_back(8'h00);
    send_frame(8'h00, 1'b1, 3);
    expect_word("glitch");
    ack_once();

    exp_q.push_back(8'hFF);
    send_frame(8'hFF, 1'b1, -1);
    expect_word("pre_rst");
    send_bit(1'b0, -1);
    for (int i = 0; i < 4; i++) send_bit(i[0], -1);
    rx = 1'b0;
    repeat (8) wait_tick();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_data", rx_data, 0);
    check("mid_rst_valid", rx_valid, 0);
    check("mid_rst_ovr", overrun, 0);
    check("mid_rst_ferr", frame_err, 0);
    rx = 1'b1;
    reset = 1'b1;
    idle(20);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, -1);
    expect_word("post_rst");
    ack_once();

    rx_ack = 1'b1;
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'h7E);
    exp_q.push_back(8'h81);
    fork
      begin
        send_frame(8'hC3, 1'b1, -1);
        send_frame(8'h7E, 1'b1, -1);
        send_frame(8'h81, 1'b1, -1);
      end
      begin
        for (int n = 0; n < 3; n++) begin
          int w;
          w = 0;
          while (!rx_valid && w < 8000) begin
            @(negedge clk);
            w++;
          end
          check("lr_valid", rx_valid, 1);
          e_lr = 8'hxx;
          if (exp_q.size() != 0) e_lr = exp_q.pop_front();
          check("lr_data", rx_data, e_lr);
          @(negedge clk);
          check("lr_one_cycle", rx_valid, 0);
        end
      end
    join
    rx_ack = 1'b0;
    check("lr_no_ovr", overrun, 0);

`ifdef UART_RX_PARITY_EN
    pe0 = pe_cnt;
    idle(4);
    par_flip = 1'b1;
    send_frame(8'h5A, 1'b1, -1);
    par_flip = 1'b0;
    idle(4);
    check("par_pulse", pe_cnt - pe0, 1);
    check("par_no_valid", rx_valid, 0);
`endif

    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_oversampled.md
# uart_rx_oversampled

16x-oversampling UART receiver. It turns the asynchronous serial line `rx` into parallel bytes using a 1-in-N enable pulse from the shared baud tick generator (100 MHz / (16 × 115200), one tick every 54 clocks). Each received word is held in a one-entry output register with a valid/ack handshake for the downstream consumer. The block sits between the board RX pin and the command/FIFO logic, mirroring the TX path.

## Interface
- `DATA_BITS`, default 8: data bits per frame (5–9), LSB first.
- `OVERSAMPLE`, default 16: ticks per bit; must match the tick generator.

Ports:
- `clk` in, 1 bit: system clock.
- `reset` in, 1 bit: asynchronous, active-low; the block is in reset while `reset`=0.
- `uart_tick` in, 1 bit: one-`clk` enable pulse at 16× baud.
- `rx` in, 1 bit: raw serial line; idle high; asynchronous to `clk`.
- `rx_data` out, `DATA_BITS`: last good received word.
- `rx_valid` out, 1 bit: `rx_data` holds an unconsumed word.
- `rx_ack` in, 1 bit: consumer takes the word this cycle.
- `frame_err` out, 1 bit: one-`clk` pulse when a stop bit is sampled 0.
- `overrun` out, 1 bit: sticky; a good word was dropped because `rx_valid` was still set.

## Operation
- `rx` passes through a 2-flop synchronizer. Both flops reset to 1.
- All state advances only on cycles with `uart_tick`=1, except the output handshake, which runs on every `clk`.
- Per-bit sample counter `scnt` counts 0..OVERSAMPLE-1.
- Samples are taken at `scnt` = 7, 8, 9. The bit value is the majority of the three and is decided on the tick where `scnt`=9.
- FSM states: IDLE → START → DATA → [PARITY] → STOP → IDLE.
- IDLE:
  - On a tick with synced `rx`=0, go to START with `scnt`=1. That tick counts as sample 0.
- START:
  - If the majority at `scnt`=9 is 1, the start was false. Return to IDLE; no error is flagged.
  - Otherwise, at `scnt`=15 go to DATA with `bit_idx`=0.
- DATA:
  - Shift the majority value into `shreg` from the MSB side, so the word ends up LSB first.
  - At `scnt`=15: if `bit_idx`=DATA_BITS-1, go to PARITY (macro defined) or STOP; else increment `bit_idx`.
- STOP:
  - Decide on the tick where `scnt`=9, then return to IDLE immediately. This leaves half a bit of margin for the next start edge.
  - Majority 1: word is good → output logic.
  - Majority 0: pulse `frame_err`; the word is discarded.
- Output register, on a good word:
  - `rx_valid`=0, or `rx_valid`=1 with `rx_ack`=1 the same cycle: load `rx_data`, set `rx_valid`=1.
  - `rx_valid`=1 with `rx_ack`=0: keep the old `rx_data`, drop the new word, set `overrun`=1.
- `rx_ack` with `rx_valid`=1 and no new word: clear `rx_valid` on the next `clk`. `rx_ack` with `rx_valid`=0 is ignored.
- `overrun` clears only on reset or on a cycle where `rx_ack`=1.
- Reset mid-frame: the FSM returns to IDLE and the partial word is lost.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `frame_err`=0, `overrun`=0, (`parity_err`=0); FSM=IDLE, `scnt`=0, `bit_idx`=0.
- Input latency: 2 `clk` through the synchronizer, plus up to 1 tick period of start-detect uncertainty.
- `rx_valid` rises 1 `clk` after the stop-bit `scnt`=9 tick.
- `frame_err` and `parity_err` are high for exactly 1 `clk`, on that same cycle.
- A consumer that holds `rx_ack` high continuously sees no gaps and no overrun at line rate.

## Configuration
- `UART_RX_PARITY_EN`:
  - Defined: adds the PARITY state, a `PARITY_ODD` parameter (default 0 = even), and a `parity_err` output pulse.
  - A parity mismatch pulses `parity_err` at the stop decision and discards the word; `rx_valid` is not set.
  - Not defined: no PARITY state and no `parity_err` port. The frame is start + DATA_BITS + stop.

## Structure
- Package `uart_pkg`:
  - FSM state enum `uart_rx_state_t`.
  - `OVERSAMPLE_DEFAULT`=16.
  - Sample-point constants `SAMPLE_LO`=7, `SAMPLE_MID`=8, `SAMPLE_HI`=9.
  - The package is shared with the TX block.
- Sub-module `uart_rx_bit_sampler`: contains the synchronizer, `scnt`, and the 3-sample majority vote. It outputs `bit_val` and `bit_strobe` (decision tick) and `bit_end` (`scnt`=15 tick). The top level holds the FSM, shift register and output handshake.

## Test plan
- Send 0xA5 at 115200 (tick every 54 `clk`), `rx_ack` tied 0 → `rx_data`=0xA5, `rx_valid`=1; assert `rx_ack` for 1 cycle → `rx_valid`=0 on the next `clk`.
- Idle line, `rx` low for 5 ticks then high → no state change past START, `rx_valid`=0, `frame_err`=0.
- Frame 0x3C with stop bit driven 0 → `frame_err` 1-cycle pulse, `rx_valid` stays 0; the following frame 0x11 is received correctly.
- Frames 0x01 then 0x02, no ack → `rx_data`=0x01, `overrun`=1; a single `rx_ack` clears both `rx_valid` and `overrun`.
- Single-tick glitch on the sample at `scnt`=8 of data bit 3 of 0x00 → `rx_data`=0x00 (majority rejects the glitch).
- `reset`=0 asserted during data bit 4, then 0x5A sent → all outputs 0 during reset, then `rx_data`=0x5A. With `UART_RX_PARITY_EN`, wrong even-parity on 0x5A → `parity_err` pulse, no `rx_valid`.
